fnd_uart_reporter: RTL and testbench

- Downstream consumer of the '@' command pulse (cmd_at) produced by the UART command decoder.
- On each trigger it snapshots the current watch/stopwatch time and formats it as an ASCII line: prefix, space, HH:MM:SS.CC, optional CR LF.
- It pushes the line byte-by-byte into the UART TX FIFO, respecting the FIFO's full flag.
- It sits between cmd_control/All_watch and the uart_tx_rx TX FIFO write port.

---
 rtl/fnd_uart_reporter.sv | 124 ++++++++++++
 tb/tb_fnd_uart_reporter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_uart_reporter.sv
// fnd_uart_reporter: on a '@' command pulse, snapshots the watch/stopwatch
// time and streams "P HH:MM:SS.CC[\r\n]" into the UART TX FIFO byte by byte.
module fnd_uart_reporter #(
    parameter logic [7:0] CHAR_WATCH = 8'h57,
    parameter logic [7:0] CHAR_SW    = 8'h53,
    parameter bit         SEND_CRLF  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trigger,
    input  logic       mode,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic [6:0] msec,
    input  logic       tx_full,
    output logic       tx_push,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, CONV, SEND, FIN} state_t;

    localparam logic [3:0] LAST = SEND_CRLF ? 4'd14 : 4'd12;

    state_t          state;
    logic [3:0]      idx;
    logic            snap_mode;
    logic [4:0]      snap_hour;
    logic [5:0]      snap_min;
    logic [5:0]      snap_sec;
    logic [6:0]      snap_msec;
    // digit bytes: [1:0]=hour, [3:2]=min, [5:4]=sec, [7:6]=centisec; odd = tens
    logic [7:0][7:0] dig;
    logic [7:0]      cur_byte;

    // Two ASCII decimal digits {tens, ones}; anything above 99 shows as "99".
    function automatic logic [15:0] to_ascii(input logic [6:0] v);
        logic [6:0] s;
        logic [6:0] t;
        s = (v > 7'd99) ? 7'd99 : v;
        t = s / 7'd10;
        return {8'h30 + {1'b0, t}, 8'h30 + {1'b0, s - t * 7'd10}};
    endfunction

    // Byte selected by the current line position.
    always_comb begin
        cur_byte = 8'h00;
        case (idx)
            4'd0:    cur_byte = snap_mode ? CHAR_SW : CHAR_WATCH;
            4'd1:    cur_byte = 8'h20;
            4'd2:    cur_byte = dig[1];
            4'd3:    cur_byte = dig[0];
            4'd4:    cur_byte = 8'h3A;
            4'd5:    cur_byte = dig[3];
            4'd6:    cur_byte = dig[2];
            4'd7:    cur_byte = 8'h3A;
            4'd8:    cur_byte = dig[5];
            4'd9:    cur_byte = dig[4];
            4'd10:   cur_byte = 8'h2E;
            4'd11:   cur_byte = dig[7];
            4'd12:   cur_byte = dig[6];
            4'd13:   cur_byte = 8'h0D;
            4'd14:   cur_byte = 8'h0A;
            default: cur_byte = 8'h00;
        endcase
    end

    // Control FSM: snapshot, convert, stream with back-pressure, finish pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 4'd0;
            tx_push   <= 1'b0;
            tx_data   <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            snap_mode <= 1'b0;
            snap_hour <= '0;
            snap_min  <= '0;
            snap_sec  <= '0;
            snap_msec <= '0;
            dig       <= '0;
        end else begin
            tx_push <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        snap_mode <= mode;
                        snap_hour <= hour;
                        snap_min  <= min;
                        snap_sec  <= sec;
                        snap_msec <= msec;
                        busy      <= 1'b1;
                        state     <= CONV;
                    end
                end
                CONV: begin
                    dig   <= {to_ascii(snap_msec), to_ascii({1'b0, snap_sec}),
                              to_ascii({1'b0, snap_min}), to_ascii({2'b00, snap_hour})};
                    idx   <= 4'd0;
                    state <= SEND;
                end
                SEND: begin
                    // the FIFO absorbs one push in the cycle full rises, so the
                    // current tx_full value is enough to decide
                    if (!tx_full) begin
                        tx_push <= 1'b1;
                        tx_data <= cur_byte;
                        idx     <= idx + 4'd1;
                        if (idx == LAST) state <= FIN;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fnd_uart_reporter.sv
// Directed bench for fnd_uart_reporter: one CRLF instance, one without.
module tb_fnd_uart_reporter;
    logic       clk = 1'b0;
    logic       rst;
    logic       trigger, mode, tx_full;
    logic [4:0] hour;
    logic [5:0] min, sec;
    logic [6:0] msec;
    logic       push0, busy0, done0, push1, busy1, done1;
    logic [7:0] data0, data1;

    int tests = 0, fails = 0;
    int cyc = 0, trig_cyc = 0;
    int first0 = 0, first1 = 0, done_cyc0 = 0, done_cyc1 = 0;
    int done_cnt0 = 0, done_cnt1 = 0, busy_bad = 0;
    logic [7:0] cap0[$], cap1[$];

    fnd_uart_reporter #(.SEND_CRLF(1'b1)) u_dut (
        .clk(clk), .rst(rst), .trigger(trigger), .mode(mode), .hour(hour),
        .min(min), .sec(sec), .msec(msec), .tx_full(tx_full),
        .tx_push(push0), .tx_data(data0), .busy(busy0), .done(done0));

    fnd_uart_reporter #(.SEND_CRLF(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .trigger(trigger), .mode(mode), .hour(hour),
        .min(min), .sec(sec), .msec(msec), .tx_full(tx_full),
        .tx_push(push1), .tx_data(data1), .busy(busy1), .done(done1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // capture pushed bytes and done pulses away from the active edge
    always @(negedge clk) begin
        if (push0) begin
            if (cap0.size() == 0) first0 = cyc;
            cap0.push_back(data0);
            if (!busy0) busy_bad++;
        end
        if (push1) begin
            if (cap1.size() == 0) first1 = cyc;
            cap1.push_back(data1);
            if (!busy1) busy_bad++;
        end
        if (done0) begin done_cnt0++; done_cyc0 = cyc; end
        if (done1) begin done_cnt1++; done_cyc1 = cyc; end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic fire();
        trigger  = 1'b1;
        trig_cyc = cyc + 1;
        step();
        trigger  = 1'b0;
    endtask

    task automatic set_in(input logic m, input logic [4:0] h, input logic [5:0] mi,
                          input logic [5:0] s, input logic [6:0] c);
        mode = m; hour = h; min = mi; sec = s; msec = c;
    endtask

    task automatic wait_done0(input string tag, input int base);
        int t = 0;
        while (done_cnt0 == base && t < 300) begin step(); t++; end
        chk({tag, "_done0"}, 32'(done_cnt0 == base + 1), 32'd1);
    endtask

    task automatic wait_done1(input string tag, input int base);
        int t = 0;
        while (done_cnt1 == base && t < 300) begin step(); t++; end
        chk({tag, "_done1"}, 32'(done_cnt1 == base + 1), 32'd1);
    endtask

    task automatic wait_size0(input string tag, input int n);
        int t = 0;
        while (cap0.size() < n && t < 300) begin step(); t++; end
        chk({tag, "_reach"}, 32'(cap0.size()), 32'(n));
    endtask

    task automatic check_cap(input string tag, input logic [7:0] q[$], input int n,
                             input logic [119:0] exp);
        chk({tag, "_len"}, 32'(q.size()), 32'(n));
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_b%0d", tag, i), (i < q.size()) ? 32'(q[i]) : 32'hFFFF_FFFF,
                32'(exp[(n-1-i)*8 +: 8]));
    endtask

    localparam logic [119:0] L1 = 120'h57_20_30_39_3A_30_35_3A_34_32_2E_30_37_0D_0A;
    localparam logic [119:0] L2 = 120'h53_20_32_33_3A_35_39_3A_35_39_2E_39_39_0D_0A;
    localparam logic [119:0] L3 = 120'h57_20_31_32_3A_36_33_3A_33_30_2E_39_39_0D_0A;
    localparam logic [119:0] LA = 120'h57_20_30_31_3A_30_32_3A_30_33_2E_30_34_0D_0A;
    localparam logic [119:0] LB = 120'h53_20_30_37_3A_30_38_3A_30_39_2E_31_30_0D_0A;
    localparam logic [119:0] L1N = 120'h57_20_30_39_3A_30_35_3A_34_32_2E_30_37;

    initial begin
        int base, tc2;
        rst = 1'b1; trigger = 1'b0; tx_full = 1'b0;
        set_in(1'b0, 5'd0, 6'd0, 6'd0, 7'd0);
        repeat (3) step();
        chk("rst_push0", 32'(push0), 32'd0);
        chk("rst_data0", 32'(data0), 32'd0);
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_done0", 32'(done0), 32'd0);
        chk("rst_push1", 32'(push1), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        rst = 1'b0;
        repeat (2) step();

        // basic line and latency
        set_in(1'b0, 5'd9, 6'd5, 6'd42, 7'd7);
        cap0.delete(); base = done_cnt0;
        fire();
        chk("t1_busy", 32'(busy0), 32'd1);
        wait_done0("t1", base);
        chk("t1_first", 32'(first0), 32'(trig_cyc + 2));
        chk("t1_donecyc", 32'(done_cyc0), 32'(trig_cyc + 17));
        check_cap("t1", cap0, 15, L1);
        step();
        chk("t1_busy_end", 32'(busy0), 32'd0);
        repeat (3) step();

        // stopwatch, inputs cleared right after the trigger
        set_in(1'b1, 5'd23, 6'd59, 6'd59, 7'd99);
        cap0.delete(); base = done_cnt0;
        fire();
        set_in(1'b0, 5'd0, 6'd0, 6'd0, 7'd0);
        wait_done0("t2", base);
        check_cap("t2", cap0, 15, L2);
        repeat (3) step();

        // saturation of the centisecond field
        set_in(1'b0, 5'd12, 6'd63, 6'd30, 7'd120);
        cap0.delete(); base = done_cnt0;
        fire();
        wait_done0("t3", base);
        check_cap("t3", cap0, 15, L3);
        repeat (3) step();

        // FIFO full for five cycles after the 4th push
        set_in(1'b0, 5'd9, 6'd5, 6'd42, 7'd7);
        cap0.delete(); base = done_cnt0;
        fire();
        wait_size0("t4", 4);
        tx_full = 1'b1;
        repeat (5) step();
        chk("t4_stalled", 32'(cap0.size()), 32'd4);
        tx_full = 1'b0;
        wait_done0("t4", base);
        check_cap("t4", cap0, 15, L1);
        repeat (20) step();

        // trigger mid-line ignored; trigger across FIN/IDLE accepted once
        set_in(1'b0, 5'd1, 6'd2, 6'd3, 7'd4);
        cap0.delete(); base = done_cnt0;
        fire();
        repeat (5) step();
        set_in(1'b1, 5'd7, 6'd8, 6'd9, 7'd10);
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        wait_size0("t5", 15);
        trigger = 1'b1;          // lands in FIN: must be ignored
        step();
        chk("t5_done_pulse", 32'(done0), 32'd1);
        tc2 = cyc + 1;           // this edge is in IDLE: accepted
        step();
        trigger = 1'b0;
        chk("t5_one_done", 32'(done_cnt0), 32'(base + 1));
        check_cap("t5a", cap0, 15, LA);
        cap0.delete(); base = done_cnt0;
        wait_done0("t5b", base);
        chk("t5b_first", 32'(first0), 32'(tc2 + 2));
        check_cap("t5b", cap0, 15, LB);
        repeat (20) step();

        // reset after the 7th push abandons the line
        set_in(1'b0, 5'd9, 6'd5, 6'd42, 7'd7);
        cap0.delete(); base = done_cnt0;
        fire();
        wait_size0("t6", 7);
        rst = 1'b1;
        #1;
        chk("t6_push_rst", 32'(push0), 32'd0);
        chk("t6_busy_rst", 32'(busy0), 32'd0);
        step();
        rst = 1'b0;
        repeat (5) step();
        chk("t6_no_more", 32'(cap0.size()), 32'd7);
        chk("t6_no_done", 32'(done_cnt0), 32'(base));
        set_in(1'b1, 5'd23, 6'd59, 6'd59, 7'd99);
        cap0.delete(); cap1.delete(); base = done_cnt0;
        fire();
        wait_done0("t6b", base);
        chk("t6b_first", 32'(first0), 32'(trig_cyc + 2));
        check_cap("t6b", cap0, 15, L2);
        repeat (20) step();

        // no-terminator instance: 13 bytes, done two cycles earlier
        set_in(1'b0, 5'd9, 6'd5, 6'd42, 7'd7);
        cap0.delete(); cap1.delete();
        base = done_cnt1;
        fire();
        wait_done1("t7", base);
        chk("t7_first", 32'(first1), 32'(trig_cyc + 2));
        chk("t7_donecyc", 32'(done_cyc1), 32'(trig_cyc + 15));
        check_cap("t7", cap1, 13, L1N);
        repeat (5) step();
        chk("t7_len_hold", 32'(cap1.size()), 32'd13);

        chk("busy_during_push", 32'(busy_bad), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
